// File: rtl/mul_pkg.sv
// Shared definitions for the pipelined RV32M multiply unit.
//   mul_op_e  : two-bit operation encoding carried on in_op
//   PROD_W    : width of the full signed/unsigned product
//   mul_sign  : maps an operation to its {rs1 signed, rs2 signed} flags
package mul_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    localparam int unsigned PROD_W = 64;

    // Returns {s1, s2}: whether rs1 / rs2 are interpreted as signed.
    function automatic logic [1:0] mul_sign(input mul_op_e op);
        logic [1:0] sgn;
        case (op)
            OP_MUL:    sgn = 2'b11;
            OP_MULH:   sgn = 2'b11;
            OP_MULHSU: sgn = 2'b10;
            OP_MULHU:  sgn = 2'b00;
            default:   sgn = 2'b00;
        endcase
        return sgn;
    endfunction

endpackage

// File: rtl/Multiplier32_archive.sv
// Combinational 32x32 multiplier with independent per-operand signedness.
//   s1, in1 : signedness flag and value of the first operand
//   s2, in2 : signedness flag and value of the second operand
//   out     : full 64-bit product
// Each operand is extended to 64 bits according to its flag; the low 64 bits
// of the extended product are exact because every signed/unsigned 32x32
// product fits in 64 bits two's complement.
module Multiplier32_archive (
    input  logic        s1,
    input  logic [31:0] in1,
    input  logic        s2,
    input  logic [31:0] in2,
    output logic [63:0] out
);

    logic [63:0] in1_ext_s;
    logic [63:0] in2_ext_s;

    // Sign- or zero-extend each operand and form the product.
    always_comb begin
        in1_ext_s = {{32{s1 & in1[31]}}, in1};
        in2_ext_s = {{32{s2 & in2[31]}}, in2};
        out       = in1_ext_s * in2_ext_s;
    end

endmodule

// File: rtl/mul_unit.sv
// Two-stage pipelined RV32M multiply unit (MUL/MULH/MULHSU/MULHU).
//   clk, rst_n            : clock, asynchronous active-low reset
//   flush                 : synchronous kill of both pipeline stages
//   in_valid/in_ready     : issue handshake; in_op/in_rs1/in_rs2/in_tag payload
//   out_valid/out_ready   : writeback handshake; out_result/out_tag payload
// S1 registers operands and signedness flags in front of the multiplier,
// S2 registers the selected product half. in_ready depends combinationally
// on out_ready so a full pipe still accepts while the head is being consumed.
import mul_pkg::*;

module mul_unit #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_rs1,
    input  logic [31:0]      in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag
);

    logic             s1_valid_q, s1_valid_d;
    logic [31:0]      s1_rs1_q,   s1_rs1_d;
    logic [31:0]      s1_rs2_q,   s1_rs2_d;
    logic             s1_sgn1_q,  s1_sgn1_d;
    logic             s1_sgn2_q,  s1_sgn2_d;
    mul_op_e          s1_op_q,    s1_op_d;
    logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;
    logic             s2_valid_q, s2_valid_d;
    logic [31:0]      s2_result_q, s2_result_d;
    logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;

    logic              s2_adv_s;
    logic              accept_s;
    logic              advance_s;
    logic [1:0]        sign_s;
    logic [PROD_W-1:0] product_s;
    logic [31:0]       half_s;

    // Handshake: S2 frees when empty or consumed; S1 frees when S2 frees.
    always_comb begin
        s2_adv_s  = !s2_valid_q || out_ready;
        in_ready  = !s1_valid_q || s2_adv_s;
        accept_s  = in_valid && in_ready && !flush;
        advance_s = s1_valid_q && s2_adv_s;
        sign_s    = mul_sign(mul_op_e'(in_op));
    end

    Multiplier32_archive u_mult (
        .s1  (s1_sgn1_q),
        .in1 (s1_rs1_q),
        .s2  (s1_sgn2_q),
        .in2 (s1_rs2_q),
        .out (product_s)
    );

    // Half select: MUL keeps the low word, every high-variant the upper word.
    always_comb begin
        case (s1_op_q)
            OP_MUL:    half_s = product_s[31:0];
            OP_MULH:   half_s = product_s[63:32];
            OP_MULHSU: half_s = product_s[63:32];
            OP_MULHU:  half_s = product_s[63:32];
            default:   half_s = product_s[63:32];
        endcase
    end

    // Next-state for both stages; payloads are untouched by flush.
    always_comb begin
        s1_rs1_d    = s1_rs1_q;
        s1_rs2_d    = s1_rs2_q;
        s1_sgn1_d   = s1_sgn1_q;
        s1_sgn2_d   = s1_sgn2_q;
        s1_op_d     = s1_op_q;
        s1_tag_d    = s1_tag_q;
        s2_result_d = s2_result_q;
        s2_tag_d    = s2_tag_q;

        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (accept_s) begin
            s1_valid_d = 1'b1;
        end else if (advance_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        if (accept_s) begin
            s1_rs1_d  = in_rs1;
            s1_rs2_d  = in_rs2;
            s1_sgn1_d = sign_s[1];
            s1_sgn2_d = sign_s[0];
            s1_op_d   = mul_op_e'(in_op);
            s1_tag_d  = in_tag;
        end else begin
            s1_rs1_d  = s1_rs1_q;
        end

        if (flush) begin
            s2_valid_d = 1'b0;
        end else if (s2_adv_s) begin
            s2_valid_d = s1_valid_q;
        end else begin
            s2_valid_d = s2_valid_q;
        end

        if (advance_s) begin
            s2_result_d = half_s;
            s2_tag_d    = s1_tag_q;
        end else begin
            s2_result_d = s2_result_q;
        end
    end

    // Pipeline state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_rs1_q    <= 32'd0;
            s1_rs2_q    <= 32'd0;
            s1_sgn1_q   <= 1'b0;
            s1_sgn2_q   <= 1'b0;
            s1_op_q     <= OP_MUL;
            s1_tag_q    <= {TAG_W{1'b0}};
            s2_valid_q  <= 1'b0;
            s2_result_q <= 32'd0;
            s2_tag_q    <= {TAG_W{1'b0}};
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_rs1_q    <= s1_rs1_d;
            s1_rs2_q    <= s1_rs2_d;
            s1_sgn1_q   <= s1_sgn1_d;
            s1_sgn2_q   <= s1_sgn2_d;
            s1_op_q     <= s1_op_d;
            s1_tag_q    <= s1_tag_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_tag_q    <= s2_tag_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_result = s2_result_q;
    assign out_tag    = s2_tag_q;

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed test-plan cases plus a
// randomized run against a queue-based reference model.
module tb_mul_unit;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        bit          in_s2;
    } item_t;

    item_t mq[$];

    mul_unit #(.TAG_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    // Architectural result of an RV32M multiply, plain 64-bit arithmetic.
    function automatic logic [31:0] ref_mul(logic [1:0] op, logic [31:0] a, logic [31:0] b);
        longint va, vb, p;
        bit sa, sb;
        sa = (op != 2'b11);
        sb = (op == 2'b00) || (op == 2'b01);
        va = sa ? longint'($signed(a)) : longint'({32'h0, a});
        vb = sb ? longint'($signed(b)) : longint'({32'h0, b});
        p  = va * vb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic bit m_out_valid();
        return (mq.size() > 0) && mq[0].in_s2;
    endfunction

    function automatic bit m_in_ready(bit ordy);
        bit s1_occ;
        s1_occ = (mq.size() > 0) && !mq[mq.size()-1].in_s2;
        return !s1_occ || !m_out_valid() || ordy;
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'h8000_0000;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h0000_0000;
            3: v = 32'h0000_0001;
            4: v = 32'h7FFF_FFFF;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Advance one clock edge and update the reference model from the driven inputs.
    task automatic tick();
        bit ov, s2adv, acc;
        item_t it;
        ov    = m_out_valid();
        s2adv = !ov || out_ready;
        acc   = in_valid && m_in_ready(out_ready) && !flush;
        it.res   = ref_mul(in_op, in_rs1, in_rs2);
        it.tag   = in_tag;
        it.in_s2 = 1'b0;
        @(posedge clk);
        if (flush) begin
            mq.delete();
        end else begin
            if (ov && out_ready) void'(mq.pop_front());
            if (s2adv) foreach (mq[i]) mq[i].in_s2 = 1'b1;
            if (acc) mq.push_back(it);
        end
        @(negedge clk);
    endtask

    task automatic offer(bit v, logic [1:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] t);
        in_valid = v;
        in_op    = op;
        in_rs1   = a;
        in_rs2   = b;
        in_tag   = t;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        offer(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
        repeat (2) @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || out_result !== 32'd0 || out_tag !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got v=%0b r=%h t=%0d want 0/0/0", out_valid, out_result, out_tag);
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready got %0b want 1", in_ready);
        end
        mq.delete();
    endtask

    task automatic test_directed();
        logic [1:0]  ops  [8] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd1, 2'd3, 2'd0, 2'd2};
        logic [31:0] opa  [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                  32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000};
        logic [31:0] exps [8] = '{32'h00000001, 32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFF,
                                  32'h40000000, 32'h40000000, 32'h00000000, 32'hC0000000};
        for (int i = 0; i < 8; i++) begin
            logic [4:0] t;
            t = (i == 0) ? 5'd3 : 5'(i + 8);
            out_ready = 1'b1;
            offer(1'b1, ops[i], opa[i], opa[i], t);
            tick();
            offer(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
            #1;
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL directed%0d_early got out_valid=%0b want 0", i, out_valid);
            end
            tick();
            #1;
            vectors++;
            if (out_valid !== 1'b1 || out_result !== exps[i] || out_tag !== t) begin
                miscompares++;
                $display("FAIL directed%0d got v=%0b r=%h t=%0d want 1 r=%h t=%0d",
                         i, out_valid, out_result, out_tag, exps[i], t);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  op [4];
        logic [31:0] a [4], b [4];
        logic [31:0] er;
        for (int i = 0; i < 4; i++) begin
            op[i] = 2'($urandom_range(0, 3));
            a[i]  = rand_operand();
            b[i]  = rand_operand();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k < 4) offer(1'b1, op[k], a[k], b[k], 5'(k + 20));
            else       offer(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
            #1;
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_in_ready cyc%0d got %0b want 1", k, in_ready);
            end
            vectors++;
            if (k >= 2 && k < 6) begin
                er = ref_mul(op[k-2], a[k-2], b[k-2]);
                if (out_valid !== 1'b1 || out_result !== er || out_tag !== 5'(k + 18)) begin
                    miscompares++;
                    $display("FAIL b2b_result cyc%0d got v=%0b r=%h t=%0d want 1 r=%h t=%0d",
                             k, out_valid, out_result, out_tag, er, k + 18);
                end
            end else if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_idle cyc%0d got out_valid=%0b want 0", k, out_valid);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] ra, rb, rc;
        ra = ref_mul(2'd1, 32'h12345678, 32'h9ABCDEF0);
        rb = ref_mul(2'd2, 32'hDEADBEEF, 32'h00000101);
        rc = ref_mul(2'd0, 32'h0000FFFF, 32'h0000FFFF);
        out_ready = 1'b0;
        offer(1'b1, 2'd1, 32'h12345678, 32'h9ABCDEF0, 5'd1);
        #1; vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_accept_a got %0b want 1", in_ready); end
        tick();
        offer(1'b1, 2'd2, 32'hDEADBEEF, 32'h00000101, 5'd2);
        #1; vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_accept_b got %0b want 1", in_ready); end
        tick();
        offer(1'b1, 2'd0, 32'h0000FFFF, 32'h0000FFFF, 5'd3);
        for (int k = 0; k < 2; k++) begin
            if (k == 1) offer(1'b1, 2'd3, 32'hFFFF0000, 32'h0F0F0F0F, 5'd31);
            #1; vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== ra || out_tag !== 5'd1) begin
                miscompares++;
                $display("FAIL bp_hold%0d got rdy=%0b v=%0b r=%h t=%0d want 0 1 r=%h t=1",
                         k, in_ready, out_valid, out_result, out_tag, ra);
            end
            tick();
        end
        out_ready = 1'b1;
        offer(1'b1, 2'd0, 32'h0000FFFF, 32'h0000FFFF, 5'd3);
        #1; vectors++;
        if (in_ready !== 1'b1 || out_result !== ra) begin
            miscompares++;
            $display("FAIL bp_release got rdy=%0b r=%h want 1 r=%h", in_ready, out_result, ra);
        end
        tick();
        offer(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
        #1; vectors++;
        if (out_valid !== 1'b1 || out_result !== rb || out_tag !== 5'd2) begin
            miscompares++;
            $display("FAIL bp_drain_b got v=%0b r=%h t=%0d want 1 r=%h t=2", out_valid, out_result, out_tag, rb);
        end
        tick();
        #1; vectors++;
        if (out_valid !== 1'b1 || out_result !== rc || out_tag !== 5'd3) begin
            miscompares++;
            $display("FAIL bp_drain_c got v=%0b r=%h t=%0d want 1 r=%h t=3", out_valid, out_result, out_tag, rc);
        end
        tick();
        #1; vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_empty got %0b want 0", out_valid); end
    endtask

    task automatic test_flush();
        logic [31:0] rd;
        out_ready = 1'b0;
        offer(1'b1, 2'd0, 32'h00000007, 32'h00000009, 5'd4);
        tick();
        offer(1'b1, 2'd0, 32'h00000003, 32'h00000005, 5'd5);
        tick();
        out_ready = 1'b1;
        flush = 1'b1;
        offer(1'b1, 2'd0, 32'h0000000B, 32'h0000000D, 5'd6);
        #1; vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_in_ready got %0b want 1", in_ready); end
        tick();
        flush = 1'b0;
        offer(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
        for (int k = 0; k < 3; k++) begin
            #1; vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL flush_killed cyc%0d got out_valid=%0b tag=%0d want 0", k, out_valid, out_tag);
            end
            tick();
        end
        rd = ref_mul(2'd3, 32'hCAFEF00D, 32'h87654321);
        offer(1'b1, 2'd3, 32'hCAFEF00D, 32'h87654321, 5'd7);
        tick();
        offer(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
        tick();
        #1; vectors++;
        if (out_valid !== 1'b1 || out_result !== rd || out_tag !== 5'd7) begin
            miscompares++;
            $display("FAIL flush_after got v=%0b r=%h t=%0d want 1 r=%h t=7", out_valid, out_result, out_tag, rd);
        end
        tick();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        offer(1'b1, 2'd1, 32'hFFFFFFFF, 32'h7FFFFFFF, 5'd9);
        tick();
        offer(1'b1, 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd10);
        tick();
        offer(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
        #2;
        rst_n = 1'b0;
        #1; vectors++;
        if (out_valid !== 1'b0 || out_result !== 32'd0 || out_tag !== 5'd0) begin
            miscompares++;
            $display("FAIL async_reset got v=%0b r=%h t=%0d want 0/0/0", out_valid, out_result, out_tag);
        end
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        offer(1'b1, 2'd3, 32'h00010000, 32'h00010000, 5'd11);
        #1; vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_ready got %0b want 1", in_ready); end
        tick();
        offer(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
        tick();
        #1; vectors++;
        if (out_valid !== 1'b1 || out_result !== 32'h00000001 || out_tag !== 5'd11) begin
            miscompares++;
            $display("FAIL post_reset_mulhu got v=%0b r=%h t=%0d want 1 r=00000001 t=11",
                     out_valid, out_result, out_tag);
        end
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            if (k < 390) begin
                offer(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                      rand_operand(), rand_operand(), 5'($urandom_range(0, 31)));
                out_ready = ($urandom_range(0, 9) < 7);
                flush     = ($urandom_range(0, 39) == 0);
            end else begin
                offer(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
                out_ready = 1'b1;
                flush     = 1'b0;
            end
            #1;
            vectors++;
            if (in_ready !== m_in_ready(out_ready) || out_valid !== m_out_valid()) begin
                miscompares++;
                $display("FAIL rand_hs cyc%0d got rdy=%0b v=%0b want rdy=%0b v=%0b",
                         k, in_ready, out_valid, m_in_ready(out_ready), m_out_valid());
            end
            if (m_out_valid()) begin
                vectors++;
                if (out_result !== mq[0].res || out_tag !== mq[0].tag) begin
                    miscompares++;
                    $display("FAIL rand_data cyc%0d got r=%h t=%0d want r=%h t=%0d",
                             k, out_result, out_tag, mq[0].res, mq[0].tag);
                end
            end
            tick();
        end
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
